// File: rtl/nfmac10g_sim_pkg.sv
// rtl/nfmac10g_sim_pkg.sv - shared XGMII/CRC constants and FSM encoding for the nfmac10g sim helpers
//
// Purpose: one place for the XGMII character set, the Ethernet CRC-32
// parameters and the frame-generator state encoding, so the stimulus
// generator and the RX checker agree on them.
// Ports: none (package).
package nfmac10g_sim_pkg;

  // XGMII characters
  localparam logic [7:0] XGMII_IDLE  = 8'h07;
  localparam logic [7:0] XGMII_START = 8'hFB;
  localparam logic [7:0] XGMII_TERM  = 8'hFD;
  localparam logic [7:0] XGMII_PRE   = 8'h55;
  localparam logic [7:0] XGMII_SFD   = 8'hD5;

  // Whole-word patterns; lane 0 is the least significant byte.
  localparam logic [63:0] XGMII_IDLE_WORD  = {8{XGMII_IDLE}};
  localparam logic [63:0] XGMII_START_WORD = {XGMII_SFD, {6{XGMII_PRE}}, XGMII_START};
  localparam logic [7:0]  XGMII_IDLE_CTRL  = 8'hFF;
  localparam logic [7:0]  XGMII_START_CTRL = 8'h01;

  // Ethernet CRC-32 (normal-form polynomial; the bytewise engine reflects it)
  localparam logic [31:0] CRC_POLY    = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;

  // Frame generator states
  localparam logic [2:0] ST_GAP   = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_TERM  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // Bit reversal, used to turn the normal-form polynomial into the
  // LSB-first form that the shift-right CRC engine needs.
  function automatic logic [31:0] reflect32(input logic [31:0] v);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      r[i] = v[31-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/crc32_d64.sv
// rtl/crc32_d64.sv - combinational Ethernet CRC-32 update over up to 8 bytes
//
// Purpose: advance a running (un-inverted) CRC-32 register by the valid
// bytes of one 64-bit XGMII word, lane 0 first. Shared by the generator
// and the RX checker.
// Ports:
//   data    in  64  byte lanes, lane 0 = [7:0]
//   valid   in  8   per-lane byte valid (contiguous from lane 0 in use)
//   crc_in  in  32  CRC register before this word
//   crc_out out 32  CRC register after this word
module crc32_d64
  import nfmac10g_sim_pkg::*;
(
  input  logic [63:0] data,
  input  logic [7:0]  valid,
  input  logic [31:0] crc_in,
  output logic [31:0] crc_out
);

  localparam logic [31:0] POLY_REFL = reflect32(CRC_POLY);

  logic [31:0] acc;

  always_comb begin
    acc = crc_in;
    for (int lane = 0; lane < 8; lane++) begin
      if (valid[lane]) begin
        acc = acc ^ {24'h000000, data[8*lane +: 8]};
        for (int b = 0; b < 8; b++) begin
          acc = acc[0] ? ((acc >> 1) ^ POLY_REFL) : (acc >> 1);
        end
      end
    end
    crc_out = acc;
  end

endmodule

// File: rtl/xgmii_rx_stim.sv
// rtl/xgmii_rx_stim.sv - synthesisable XGMII receive-side frame generator
//
// Purpose: drives the MAC receive XGMII pins with a deterministic stream of
// Ethernet frames (preamble/SFD, counting payload, FCS optionally corrupted,
// terminate) separated by an idle gap, and keeps running totals for the
// RX-side checker.
// Ports:
//   clk          in  1   rising-edge clock
//   aresetn      in  1   asynchronous active-low reset
//   enable       in  1   permits starting new frames
//   xgmii_rxd    out 64  XGMII data, lane 0 = [7:0], first on the wire
//   xgmii_rxc    out 8   XGMII control, one bit per lane
//   frames_sent  out 64  frames whose terminate word has been emitted
//   bad_frames   out 64  of those, frames sent with a corrupted FCS
//   done         out 1   sticky, set with the terminate of the last frame
module xgmii_rx_stim
  import nfmac10g_sim_pkg::*;
#(
  parameter int NUM_FRAMES = 1000,
  parameter int MIN_LEN    = 60,
  parameter int MAX_LEN    = 1514,
  parameter int IFG_BYTES  = 12,
  parameter int BAD_EVERY  = 0
) (
  input  logic        clk,
  input  logic        aresetn,
  input  logic        enable,
  output logic [63:0] xgmii_rxd,
  output logic [7:0]  xgmii_rxc,
  output logic [63:0] frames_sent,
  output logic [63:0] bad_frames,
  output logic        done
);

  localparam logic [15:0] MIN_L = 16'(MIN_LEN);
  localparam logic [15:0] MAX_L = 16'(MAX_LEN);
  localparam logic [15:0] IFG_L = 16'(IFG_BYTES);
  localparam logic [31:0] BAD_N = 32'(BAD_EVERY);
  localparam logic [63:0] NUM_F = 64'(NUM_FRAMES);

  // Frame state
  logic [2:0]  state;
  logic [15:0] word_idx;    // index of the next post-start word to emit
  logic [15:0] frame_len;   // payload bytes of the current frame
  logic [7:0]  frame_lo;    // frame number mod 256, the payload seed
  logic [31:0] bad_phase;   // (frame number + 1) folded into 1..BAD_EVERY
  logic [31:0] crc_q;       // CRC over payload words already emitted
  logic [15:0] gap_cnt;     // idle lanes seen since the last terminate

  // Word builder
  logic [15:0] base_idx;
  logic [15:0] term_idx;
  logic [15:0] lane_idx [8];
  logic [63:0] pay_data;
  logic [7:0]  pay_valid;
  logic [31:0] crc_next;
  logic [31:0] fcs;
  logic        bad_frame;
  logic        last_word;
  logic [63:0] data_d;
  logic [7:0]  ctrl_d;
  logic [15:0] idle_after;

  function automatic logic [7:0] fcs_lane(input logic [31:0] f, input logic [1:0] sel);
    logic [7:0] r;
    case (sel)
      2'd0:    r = f[7:0];
      2'd1:    r = f[15:8];
      2'd2:    r = f[23:16];
      default: r = f[31:24];
    endcase
    return r;
  endfunction

  // Byte stream after the start word: payload [0, L), FCS [L, L+4),
  // terminate at L+4, idle fill after that.
  assign base_idx = word_idx << 3;
  assign term_idx = frame_len + 16'd4;

  always_comb begin
    for (int lane = 0; lane < 8; lane++) begin
      lane_idx[lane] = base_idx + 16'(lane);
    end
  end

  always_comb begin
    pay_data  = '0;
    pay_valid = '0;
    for (int lane = 0; lane < 8; lane++) begin
      if (lane_idx[lane] < frame_len) begin
        pay_valid[lane]         = 1'b1;
        pay_data[8*lane +: 8]   = frame_lo + lane_idx[lane][7:0];
      end
    end
  end

  // crc_next covers every payload byte up to and including this word, so it
  // is already final in whichever word(s) carry the FCS bytes.
  crc32_d64 u_crc (
    .data    (pay_data),
    .valid   (pay_valid),
    .crc_in  (crc_q),
    .crc_out (crc_next)
  );

  assign fcs       = crc_next ^ 32'hFFFFFFFF;
  assign bad_frame = (BAD_N != 32'd0) && (bad_phase == BAD_N);
  assign last_word = (term_idx <= base_idx + 16'd7);
  // Idle lanes left in the terminate word (lanes above the FD).
  assign idle_after = 16'(3'd7 - term_idx[2:0]);

  always_comb begin
    data_d = '0;
    ctrl_d = '0;
    for (int lane = 0; lane < 8; lane++) begin
      if (lane_idx[lane] < frame_len) begin
        data_d[8*lane +: 8] = pay_data[8*lane +: 8];
      end else if (lane_idx[lane] < term_idx) begin
        data_d[8*lane +: 8] = fcs_lane(fcs, lane_idx[lane][1:0] - frame_len[1:0]);
        if ((lane_idx[lane] == frame_len) && bad_frame) begin
          data_d[8*lane +: 8] = ~data_d[8*lane +: 8];
        end
      end else if (lane_idx[lane] == term_idx) begin
        data_d[8*lane +: 8] = XGMII_TERM;
        ctrl_d[lane]        = 1'b1;
      end else begin
        data_d[8*lane +: 8] = XGMII_IDLE;
        ctrl_d[lane]        = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state       <= ST_GAP;
      word_idx    <= '0;
      frame_len   <= MIN_L;
      frame_lo    <= '0;
      bad_phase   <= 32'd1;
      crc_q       <= CRC_INIT;
      gap_cnt     <= IFG_L;
      xgmii_rxd   <= XGMII_IDLE_WORD;
      xgmii_rxc   <= XGMII_IDLE_CTRL;
      frames_sent <= '0;
      bad_frames  <= '0;
      done        <= 1'b0;
    end else begin
      xgmii_rxd <= XGMII_IDLE_WORD;
      xgmii_rxc <= XGMII_IDLE_CTRL;
      case (state)
        ST_GAP: begin
          if ((gap_cnt >= IFG_L) && enable && !done) begin
            xgmii_rxd <= XGMII_START_WORD;
            xgmii_rxc <= XGMII_START_CTRL;
            word_idx  <= '0;
            crc_q     <= CRC_INIT;
            state     <= ST_START;
          end else if (gap_cnt < IFG_L) begin
            gap_cnt <= gap_cnt + 16'd8;
          end
        end

        ST_START, ST_DATA: begin
          xgmii_rxd <= data_d;
          xgmii_rxc <= ctrl_d;
          crc_q     <= crc_next;
          word_idx  <= word_idx + 16'd1;
          if (last_word) begin
            state       <= ST_TERM;
            gap_cnt     <= idle_after;
            frames_sent <= frames_sent + 64'd1;
            if (bad_frame) begin
              bad_frames <= bad_frames + 64'd1;
            end
            if (frames_sent + 64'd1 == NUM_F) begin
              done <= 1'b1;
            end
            frame_len <= (frame_len >= MAX_L) ? MIN_L : frame_len + 16'd1;
            frame_lo  <= frame_lo + 8'd1;
            bad_phase <= (bad_phase >= BAD_N) ? 32'd1 : bad_phase + 32'd1;
          end else begin
            state <= ST_DATA;
          end
        end

        ST_TERM: begin
          if (gap_cnt < IFG_L) begin
            gap_cnt <= gap_cnt + 16'd8;
          end
          state <= done ? ST_DONE : ST_GAP;
        end

        ST_DONE: begin
          state <= ST_DONE;
        end

        default: begin
          state <= ST_GAP;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xgmii_rx_stim.sv
// tb/tb_xgmii_rx_stim.sv - self-checking bench for xgmii_rx_stim
module tb_xgmii_rx_stim;

  localparam int P_NUM = 14;
  localparam int P_MIN = 60;
  localparam int P_MAX = 63;
  localparam int P_IFG = 12;
  localparam int P_BAD = 4;

  localparam logic [63:0] W_IDLE  = 64'h0707070707070707;
  localparam logic [63:0] W_START = 64'hD5555555555555FB;
  localparam logic [63:0] W_TERM0 = 64'h07070707070707FD;

  logic        clk;
  logic        aresetn;
  logic        enable;
  logic [63:0] xgmii_rxd;
  logic [7:0]  xgmii_rxc;
  logic [63:0] frames_sent;
  logic [63:0] bad_frames;
  logic        done;

  xgmii_rx_stim #(
    .NUM_FRAMES (P_NUM),
    .MIN_LEN    (P_MIN),
    .MAX_LEN    (P_MAX),
    .IFG_BYTES  (P_IFG),
    .BAD_EVERY  (P_BAD)
  ) dut (
    .clk         (clk),
    .aresetn     (aresetn),
    .enable      (enable),
    .xgmii_rxd   (xgmii_rxd),
    .xgmii_rxc   (xgmii_rxc),
    .frames_sent (frames_sent),
    .bad_frames  (bad_frames),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h000000, b};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  // The good-frame residue in the LSB-first register is the bit reverse of
  // the normal-form constant.
  function automatic logic [31:0] residue_refl();
    logic [31:0] n;
    logic [31:0] r;
    n = 32'hC704DD7B;
    for (int i = 0; i < 32; i++) r[i] = n[31-i];
    return r;
  endfunction

  // ---------------- reference model: wire parser ----------------
  logic       in_frame_m;
  int         k_m;
  int         bad_m;
  logic       seen_term_m;
  int         idle_words_m;
  int         idle_lanes_m;
  logic [7:0] fq[$];

  task automatic model_reset();
    in_frame_m   = 1'b0;
    k_m          = 0;
    bad_m        = 0;
    seen_term_m  = 1'b0;
    idle_words_m = 0;
    idle_lanes_m = 0;
    fq.delete();
  endtask

  task automatic check_word(input logic en_edge);
    logic       gap_ok, exp_start, is_start, is_idle;
    logic       term_here, lay_ok, pay_ok, bad;
    logic [7:0] by, e;
    logic [31:0] c, r, efcs, afcs;
    int         tlane, len;
    if (!in_frame_m) begin
      gap_ok    = !seen_term_m || (idle_words_m >= 1 && idle_lanes_m >= P_IFG);
      exp_start = gap_ok && en_edge && (k_m < P_NUM);
      is_start  = (xgmii_rxd == W_START) && (xgmii_rxc == 8'h01);
      is_idle   = (xgmii_rxd == W_IDLE) && (xgmii_rxc == 8'hFF);
      check("gap_or_start_word", {62'd0, is_start, is_idle}, exp_start ? 64'd2 : 64'd1);
      check("frames_sent_idle", frames_sent, 64'(k_m));
      check("done_idle", {63'd0, done}, {63'd0, (k_m == P_NUM)});
      if (is_start) begin
        in_frame_m = 1'b1;
        fq.delete();
      end else if (is_idle) begin
        idle_words_m++;
        idle_lanes_m += 8;
      end
    end else begin
      term_here = 1'b0;
      lay_ok    = 1'b1;
      tlane     = 0;
      for (int b = 0; b < 8; b++) begin
        by = xgmii_rxd[8*b +: 8];
        if (!term_here) begin
          if (!xgmii_rxc[b]) fq.push_back(by);
          else begin
            term_here = 1'b1;
            tlane     = b;
            if (by != 8'hFD) lay_ok = 1'b0;
          end
        end else if (!xgmii_rxc[b] || by != 8'h07) begin
          lay_ok = 1'b0;
        end
      end
      check("frame_lane_layout", {63'd0, lay_ok}, 64'd1);
      check("frames_sent_frame", frames_sent, 64'(term_here ? k_m + 1 : k_m));
      if (term_here) begin
        len = P_MIN + (k_m % (P_MAX - P_MIN + 1));
        bad = (P_BAD > 0) && (((k_m + 1) % P_BAD) == 0);
        if (bad) bad_m++;
        check("frame_bytes", 64'(fq.size()), 64'(len + 4));
        pay_ok = 1'b1;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < len; i++) begin
          e = 8'((k_m + i) % 256);
          if (i >= fq.size() || fq[i] != e) pay_ok = 1'b0;
          c = crc_step(c, e);
        end
        check("payload", {63'd0, pay_ok}, 64'd1);
        efcs = ~c;
        if (bad) efcs[7:0] = ~efcs[7:0];
        afcs = '0;
        if (fq.size() == len + 4) afcs = {fq[len+3], fq[len+2], fq[len+1], fq[len]};
        check("fcs", {32'd0, afcs}, {32'd0, efcs});
        r = 32'hFFFFFFFF;
        foreach (fq[i]) r = crc_step(r, fq[i]);
        check("crc_residue_good", {63'd0, (r == residue_refl())}, {63'd0, !bad});
        check("bad_frames", bad_frames, 64'(bad_m));
        check("done_at_term", {63'd0, done}, {63'd0, (k_m + 1 == P_NUM)});
        k_m++;
        in_frame_m   = 1'b0;
        seen_term_m  = 1'b1;
        idle_words_m = 0;
        idle_lanes_m = 7 - tlane;
        fq.delete();
      end
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        rstn;
    logic        en;
    logic [7:0]  rxc;
    logic [63:0] rxd;
    logic [63:0] fs;
  } vec_t;

  vec_t tbl[15];

  function automatic logic [63:0] frame_word(input int k, input int len, input int w,
                                             input logic [31:0] f);
    logic [63:0] v;
    int j;
    v = '0;
    for (int b = 0; b < 8; b++) begin
      j = 8 * w + b;
      if (j < len) v[8*b +: 8] = 8'((k + j) % 256);
      else         v[8*b +: 8] = f[8*(j-len) +: 8];
    end
    return v;
  endfunction

  logic [31:0] fcs0;
  logic        en_edge;
  int          gate;
  int          post_done;

  initial begin
    aresetn = 1'b0;
    enable  = 1'b0;

    fcs0 = 32'hFFFFFFFF;
    for (int i = 0; i < P_MIN; i++) fcs0 = crc_step(fcs0, 8'(i));
    fcs0 = ~fcs0;

    tbl[0] = '{1'b0, 1'b0, 8'hFF, W_IDLE, 64'd0};
    tbl[1] = '{1'b1, 1'b1, 8'h01, W_START, 64'd0};
    for (int w = 0; w < 8; w++) tbl[2+w] = '{1'b1, 1'b1, 8'h00, frame_word(0, P_MIN, w, fcs0), 64'd0};
    tbl[10] = '{1'b1, 1'b1, 8'hFF, W_TERM0, 64'd1};
    tbl[11] = '{1'b1, 1'b1, 8'hFF, W_IDLE, 64'd1};
    tbl[12] = '{1'b1, 1'b1, 8'h01, W_START, 64'd1};
    tbl[13] = '{1'b1, 1'b1, 8'h00, frame_word(1, P_MIN + 1, 0, 32'd0), 64'd1};
    tbl[14] = '{1'b1, 1'b1, 8'h00, frame_word(1, P_MIN + 1, 1, 32'd0), 64'd1};

    for (int i = 0; i < 15; i++) begin
      aresetn = tbl[i].rstn;
      enable  = tbl[i].en;
      @(posedge clk);
      #1;
      check($sformatf("tbl%0d_rxc", i), {56'd0, xgmii_rxc}, {56'd0, tbl[i].rxc});
      check($sformatf("tbl%0d_rxd", i), xgmii_rxd, tbl[i].rxd);
      check($sformatf("tbl%0d_frames_sent", i), frames_sent, tbl[i].fs);
    end

    // Reset asserted in the middle of frame 1: outputs go idle at once.
    @(negedge clk);
    aresetn = 1'b0;
    #1;
    check("rst_rxd", xgmii_rxd, W_IDLE);
    check("rst_rxc", {56'd0, xgmii_rxc}, 64'h00000000000000FF);
    check("rst_frames_sent", frames_sent, 64'd0);
    check("rst_bad_frames", bad_frames, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    @(posedge clk);
    #1;
    check("rst_held_rxc", {56'd0, xgmii_rxc}, 64'h00000000000000FF);
    @(negedge clk);
    aresetn = 1'b1;
    enable  = 1'b1;

    // Free run from frame 0 against the parser model, with one forced
    // enable-low window during frame 5 and random enable afterwards.
    model_reset();
    gate      = -1;
    post_done = 0;
    for (int cyc = 0; cyc < 4000 && post_done < 40; cyc++) begin
      en_edge = enable;
      @(posedge clk);
      #1;
      check_word(en_edge);
      if (k_m == P_NUM) post_done++;
      if (gate < 0 && k_m == 5 && in_frame_m) gate = 25;
      if (gate > 0) begin
        enable = 1'b0;
        gate--;
      end else if (k_m < 5) begin
        enable = 1'b1;
      end else begin
        enable = ($urandom_range(0, 3) != 0);
      end
    end

    check("frames_completed", 64'(k_m), 64'(P_NUM));
    check("final_frames_sent", frames_sent, 64'(P_NUM));
    check("final_bad_frames", bad_frames, 64'd3);
    check("final_done", {63'd0, done}, 64'd1);
    check("final_idle_rxd", xgmii_rxd, W_IDLE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
